i2c_slave_clk_mult: RTL and testbench

- Synchronous, parametrised clock multiplier for the I2C slave path. Replaces delay-line XOR doubling with fully clocked logic.
- Synchronises the external SCL into the iclk domain and produces single-cycle rise, fall and both-edge strobes.
- Measures the SCL period and, once locked, emits 2^MULT_LOG2 evenly spaced ticks per SCL period, plus a regenerated square wave oclk at (2^MULT_LOG2)/2 × f_scl.
- Default configuration gives oclk = 2× SCL.

---
 rtl/i2c_slave_clk_mult.sv | 140 ++++++++++++++
 tb/tb_i2c_slave_clk_mult.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_clk_mult.sv
// Clocked SCL multiplier: synchronises SCL, strobes its edges, measures its
// period and, once locked, emits 2^MULT_LOG2 evenly spaced ticks per period
// plus a regenerated square wave at (2^MULT_LOG2)/2 times the SCL rate.
module i2c_slave_clk_mult #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MULT_LOG2   = 2
) (
  input  logic             iclk,
  input  logic             reset,
  input  logic             scl_in,
  output logic             scl_sync,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             edge_pulse,
  output logic             mult_tick,
  output logic             oclk,
  output logic             locked,
  output logic [CNT_W-1:0] period
);

  localparam int unsigned          MULT     = 1 << MULT_LOG2;
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]     LOCK_MIN = CNT_W'(2 * MULT);
  localparam logic [MULT_LOG2-1:0] IDX_LAST = MULT_LOG2'(MULT - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       phase;
  logic [CNT_W-1:0]       step;
  logic [MULT_LOG2-1:0]   idx;
  state_t                 state;

  assign scl_sync = sync_q[SYNC_STAGES-1];
  assign rise     = scl_sync & ~prev;
  assign fall     = ~scl_sync & prev;

  // Multi-flop synchroniser for the asynchronous SCL input
  always_ff @(posedge iclk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], scl_in};
  end

  // Registered edge strobes
  always_ff @(posedge iclk) begin
    if (reset) begin
      prev       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      prev       <= scl_sync;
      rise_pulse <= rise;
      fall_pulse <= fall;
      edge_pulse <= rise | fall;
    end
  end

  // Rise-to-rise period counter, saturating so a stalled SCL can be detected
  always_ff @(posedge iclk) begin
    if (reset)               cnt <= '0;
    else if (rise)           cnt <= CNT_W'(1);
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  // Lock FSM with tick sequencer and oclk regeneration
  always_ff @(posedge iclk) begin
    if (reset) begin
      state     <= IDLE;
      locked    <= 1'b0;
      mult_tick <= 1'b0;
      oclk      <= 1'b0;
      period    <= '0;
      phase     <= '0;
      step      <= '0;
      idx       <= '0;
    end else begin
      mult_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (cnt == CNT_MAX) begin
            state  <= IDLE;
            period <= '0;
          end else if (rise) begin
            period <= cnt;
            if (cnt >= LOCK_MIN) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              mult_tick <= 1'b1;
              idx       <= '0;
              phase     <= CNT_W'(1);
              step      <= cnt >> MULT_LOG2;
              oclk      <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (cnt == CNT_MAX) begin
            state  <= IDLE;
            locked <= 1'b0;
            oclk   <= 1'b0;
            period <= '0;
          end else if (rise) begin
            period <= cnt;
            if (cnt < LOCK_MIN) begin
              state  <= MEASURE;
              locked <= 1'b0;
              oclk   <= 1'b0;
            end else begin
              // a rise always restarts the tick sequence
              mult_tick <= 1'b1;
              idx       <= '0;
              phase     <= CNT_W'(1);
              step      <= cnt >> MULT_LOG2;
              oclk      <= 1'b1;
            end
          end else if (idx < IDX_LAST && phase == step) begin
            mult_tick <= 1'b1;
            idx       <= idx + MULT_LOG2'(1);
            phase     <= CNT_W'(1);
            // new idx is even exactly when the current one is odd
            oclk      <= idx[0];
          end else begin
            phase <= phase + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_clk_mult.sv
// Directed bench for i2c_slave_clk_mult: edge-latency vector table, then
// hand-written lock, period-change, timeout, too-fast and reset sequences.
module tb_i2c_slave_clk_mult;

  logic        iclk = 1'b0;
  logic        reset;
  logic        scl_in;
  logic        scl_sync;
  logic        rise_pulse;
  logic        fall_pulse;
  logic        edge_pulse;
  logic        mult_tick;
  logic        oclk;
  logic        locked;
  logic [15:0] period;

  i2c_slave_clk_mult #(.SYNC_STAGES(2), .CNT_W(16), .MULT_LOG2(2)) dut (
    .iclk(iclk), .reset(reset), .scl_in(scl_in), .scl_sync(scl_sync),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .edge_pulse(edge_pulse),
    .mult_tick(mult_tick), .oclk(oclk), .locked(locked), .period(period)
  );

  always #5 iclk = ~iclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // event logs, cycle-stamped by the monitor
  int rise_log[$];
  int per_log[$];
  int tick_log[$];
  int oclk_log[$];
  int lock_log[$];
  logic locked_d = 1'b0;
  logic oclk_d   = 1'b0;

  localparam int EV_TICK = 0;
  localparam int EV_OCLK = 1;
  localparam int EV_LOCK = 2;

  always @(posedge iclk) cyc <= cyc + 1;

  // monitor: record strobes and level changes away from the active edge
  always @(negedge iclk) begin
    if (rise_pulse) begin
      rise_log.push_back(cyc);
      per_log.push_back(int'(period));
    end
    if (mult_tick) tick_log.push_back(cyc);
    if (oclk !== oclk_d) oclk_log.push_back(cyc);
    if (locked !== locked_d) lock_log.push_back(cyc);
    oclk_d   <= oclk;
    locked_d <= locked;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int ev_cnt(input int which, input int lo, input int hi);
    int q[$];
    int n = 0;
    case (which)
      EV_TICK: q = tick_log;
      EV_OCLK: q = oclk_log;
      default: q = lock_log;
    endcase
    foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
    return n;
  endfunction

  function automatic int ev_at(input int which, input int lo, input int hi, input int k);
    int q[$];
    int n = 0;
    case (which)
      EV_TICK: q = tick_log;
      EV_OCLK: q = oclk_log;
      default: q = lock_log;
    endcase
    foreach (q[i]) begin
      if (q[i] >= lo && q[i] < hi) begin
        if (n == k) return q[i];
        n++;
      end
    end
    return -1;
  endfunction

  // drive scl_in for n active edges, changing it just after an edge
  task automatic hold(input logic val, input int n);
    scl_in = val;
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " scl_sync"},   int'(scl_sync),   0);
    chk({tag, " rise_pulse"}, int'(rise_pulse), 0);
    chk({tag, " fall_pulse"}, int'(fall_pulse), 0);
    chk({tag, " edge_pulse"}, int'(edge_pulse), 0);
    chk({tag, " mult_tick"},  int'(mult_tick),  0);
    chk({tag, " oclk"},       int'(oclk),       0);
    chk({tag, " locked"},     int'(locked),     0);
    chk({tag, " period"},     int'(period),     0);
  endtask

  typedef struct {
    logic       rst;
    logic       scl;
    logic [3:0] exp; // {scl_sync, rise_pulse, fall_pulse, edge_pulse}
  } vec_t;

  vec_t vecs[12];

  initial begin
    int r0, l0, f0, m0, rst_cyc, fall_c;
    int r1, r2, r3, r6, r7, rc, rd;

    reset  = 1'b1;
    scl_in = 1'b0;

    // reset held 3 cycles with SCL toggling, then rise at E0 (entry 4) and fall
    vecs[0]  = '{1'b1, 1'b1, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 4'b0000};
    vecs[2]  = '{1'b1, 1'b1, 4'b0000};
    vecs[3]  = '{1'b0, 1'b0, 4'b0000};
    vecs[4]  = '{1'b0, 1'b1, 4'b0000};
    vecs[5]  = '{1'b0, 1'b1, 4'b1000};
    vecs[6]  = '{1'b0, 1'b1, 4'b1101};
    vecs[7]  = '{1'b0, 1'b1, 4'b1000};
    vecs[8]  = '{1'b0, 1'b0, 4'b1000};
    vecs[9]  = '{1'b0, 1'b0, 4'b0000};
    vecs[10] = '{1'b0, 1'b0, 4'b0011};
    vecs[11] = '{1'b0, 1'b0, 4'b0000};

    @(negedge iclk);
    for (int i = 0; i < 12; i++) begin
      reset  = vecs[i].rst;
      scl_in = vecs[i].scl;
      @(posedge iclk);
      @(negedge iclk);
      chk($sformatf("vec%0d strobes", i),
          int'({scl_sync, rise_pulse, fall_pulse, edge_pulse}), int'(vecs[i].exp));
      chk($sformatf("vec%0d tick/oclk/locked", i), int'({mult_tick, oclk, locked}), 0);
      chk($sformatf("vec%0d period", i), int'(period), 0);
    end

    // ---- lock at 400, then period change to 320 ----
    reset = 1'b1;
    hold(1'b0, 2);
    reset = 1'b0;
    hold(1'b0, 10);
    r0 = rise_log.size();
    l0 = lock_log.size();
    repeat (4) begin hold(1'b1, 200); hold(1'b0, 200); end
    repeat (3) begin hold(1'b1, 160); hold(1'b0, 160); end

    chk("lock rise count", rise_log.size() - r0, 7);
    r1 = rise_log[r0];
    r2 = rise_log[r0 + 1];
    r3 = rise_log[r0 + 2];
    r6 = rise_log[r0 + 5];
    r7 = rise_log[r0 + 6];
    chk("rise spacing 400", r2 - r1, 400);
    chk("rise spacing 320", r7 - r6, 320);
    chk("first rise keeps period", per_log[r0], 0);
    chk("period at 2nd rise", per_log[r0 + 1], 400);
    chk("period at 6th rise", per_log[r0 + 5], 320);
    chk("lock event count", lock_log.size() - l0, 1);
    chk("lock on 2nd rise", lock_log[l0], r2);
    chk("no ticks before lock", ev_cnt(EV_TICK, r1, r2), 0);
    chk("ticks per 400 period", ev_cnt(EV_TICK, r2, r3), 4);
    chk("oclk edges per 400 period", ev_cnt(EV_OCLK, r2, r3), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tick%0d offset @400", k), ev_at(EV_TICK, r2, r3, k) - r2, k * 100);
      chk($sformatf("oclk edge%0d offset @400", k), ev_at(EV_OCLK, r2, r3, k) - r2, k * 100);
      chk($sformatf("tick%0d offset @320", k), ev_at(EV_TICK, r6, r7, k) - r6, k * 80);
    end
    chk("ticks per 320 period", ev_cnt(EV_TICK, r6, r7), 4);
    chk("locked held", int'(locked), 1);
    chk("period now 320", int'(period), 320);

    // ---- timeout: SCL stalls low ----
    hold(1'b0, 65500);
    chk("timeout locked", int'(locked), 0);
    chk("timeout oclk", int'(oclk), 0);
    chk("timeout period", int'(period), 0);
    chk("timeout lock events", lock_log.size() - l0, 2);
    fall_c = lock_log[lock_log.size() - 1];
    chk("timeout delay in window",
        int'((fall_c - r7 >= 65534) && (fall_c - r7 <= 65535)), 1);
    chk("no ticks after last sequence", ev_cnt(EV_TICK, r7 + 241, cyc + 1), 0);

    // ---- too fast: 6-cycle SCL period ----
    f0 = rise_log.size();
    l0 = lock_log.size();
    repeat (20) begin hold(1'b1, 3); hold(1'b0, 3); end
    chk("fast rise count", rise_log.size() - f0, 20);
    chk("fast rise spacing", rise_log[f0 + 1] - rise_log[f0], 6);
    chk("fast first period", per_log[f0], 0);
    chk("fast measured period", per_log[f0 + 1], 6);
    chk("fast no lock", lock_log.size() - l0, 0);
    chk("fast no ticks", ev_cnt(EV_TICK, rise_log[f0], cyc + 1), 0);
    chk("fast locked", int'(locked), 0);

    // ---- reset during the 2nd tick interval, then relock ----
    hold(1'b1, 200);
    hold(1'b0, 200);
    hold(1'b1, 150);
    chk("pre-reset locked", int'(locked), 1);
    chk("pre-reset period", int'(period), 400);
    m0 = rise_log.size();
    reset = 1'b1;
    hold(1'b1, 1);
    rst_cyc = cyc;
    chk_all_zero("reset");
    reset = 1'b0;
    hold(1'b1, 50);
    hold(1'b0, 200);
    hold(1'b1, 200);
    hold(1'b0, 60);
    chk("relock rise count", rise_log.size() - m0, 2);
    rc = rise_log[m0];
    rd = rise_log[m0 + 1];
    chk("relock rise spacing", rd - rc, 250);
    chk("relock first period", per_log[m0], 0);
    chk("relock period", per_log[m0 + 1], 250);
    chk("relock lock event", lock_log[lock_log.size() - 1], rd);
    chk("no ticks before relock", ev_cnt(EV_TICK, rst_cyc, rd), 0);
    chk("relock tick count", ev_cnt(EV_TICK, rd, cyc + 1), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("relock tick%0d offset", k), ev_at(EV_TICK, rd, cyc + 1, k) - rd, k * 62);
    chk("relocked", int'(locked), 1);
    chk("relock period now", int'(period), 250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
